// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX/MEM and MEM/WB
// operand forwarding and ALU operand muxing.
// Optional build macro: ID_EX_STALL_CNT_EN adds a saturating 16-bit
// stall_count output that counts inserted load-use bubbles.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [4:0]  in_aluop,
  input  logic        in_op1_sel,
  input  logic        in_op2_sel,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [4:0]  exmem_rd_addr,
  input  logic        exmem_reg_write,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd_addr,
  input  logic        memwb_reg_write,
  input  logic [31:0] memwb_result,
  input  logic        flush,
  input  logic        hold,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [4:0]  select,
  output logic        out_valid,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_pc,
  output logic [31:0] out_store_data,
  output logic        stall
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned OPW    = 5;
  localparam int unsigned CNT_W  = 16;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [AW-1:0]   rs1_addr_q;
  logic [AW-1:0]   rs2_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic [OPW-1:0]  aluop_q;
  logic            op1_sel_q;
  logic            op2_sel_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic            reg_write_q;

  logic            hazard_c;
  logic [XLEN-1:0] fwd_rs1_c;
  logic [XLEN-1:0] fwd_rs2_c;

  // Load-use hazard: a load in EX whose rd is read by the incoming instruction
  always_comb begin
    hazard_c = 1'b0;
    if (valid_q && mem_read_q && (rd_addr_q != AW'(0)) && in_valid &&
        ((in_rs1_addr == rd_addr_q) || (in_rs2_addr == rd_addr_q)))
      hazard_c = 1'b1;
  end

  // Pipeline register: flush > hold > bubble > normal load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      aluop_q     <= '0;
      op1_sel_q   <= 1'b0;
      op2_sel_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush || (!hold && hazard_c)) begin
      // Bubble: kill control, leave data fields as they are
      valid_q     <= 1'b0;
      aluop_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!hold) begin
      valid_q     <= in_valid;
      pc_q        <= in_pc;
      rs1_data_q  <= in_rs1_data;
      rs2_data_q  <= in_rs2_data;
      imm_q       <= in_imm;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rd_addr_q   <= in_rd_addr;
      op1_sel_q   <= in_op1_sel;
      op2_sel_q   <= in_op2_sel;
      aluop_q     <= in_valid ? in_aluop : OPW'(0);
      mem_read_q  <= in_valid & in_mem_read;
      mem_write_q <= in_valid & in_mem_write;
      reg_write_q <= in_valid & in_reg_write;
    end
  end

  // Operand forwarding; EX/MEM has priority, x0 is never forwarded
  always_comb begin
    fwd_rs1_c = rs1_data_q;
    fwd_rs2_c = rs2_data_q;
    if (exmem_reg_write && (exmem_rd_addr != AW'(0)) && (exmem_rd_addr == rs1_addr_q))
      fwd_rs1_c = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr != AW'(0)) && (memwb_rd_addr == rs1_addr_q))
      fwd_rs1_c = memwb_result;
    if (exmem_reg_write && (exmem_rd_addr != AW'(0)) && (exmem_rd_addr == rs2_addr_q))
      fwd_rs2_c = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr != AW'(0)) && (memwb_rd_addr == rs2_addr_q))
      fwd_rs2_c = memwb_result;
  end

  // ALU operand muxing and valid-gated control outputs
  always_comb begin
    data1          = op1_sel_q ? pc_q : fwd_rs1_c;
    data2          = op2_sel_q ? imm_q : fwd_rs2_c;
    out_store_data = fwd_rs2_c;
    select         = valid_q ? aluop_q : OPW'(0);
    out_valid      = valid_q;
    out_mem_read   = valid_q & mem_read_q;
    out_mem_write  = valid_q & mem_write_q;
    out_reg_write  = valid_q & reg_write_q;
    out_rd_addr    = rd_addr_q;
    out_pc         = pc_q;
    stall          = (hazard_c | hold) & ~flush;
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (hazard_c && !hold && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  aluop;
    logic        op1sel;
    logic        op2sel;
    logic        mr;
    logic        mw;
    logic        rw;
  } instr_t;

  logic        clk;
  logic        reset;
  instr_t      cur;
  logic [4:0]  ex_rd, wb_rd;
  logic        ex_rw, wb_rw;
  logic [31:0] ex_res, wb_res;
  logic        flush, hold;

  logic [31:0] data1, data2, out_pc, out_store_data;
  logic [4:0]  select, out_rd_addr;
  logic        out_valid, out_mem_read, out_mem_write, out_reg_write, stall;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_t      m;      // instruction currently held in EX, per the model
  instr_t      nm;
  int unsigned cnt;    // modelled bubble count

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(cur.valid), .in_pc(cur.pc), .in_rs1_data(cur.rs1d),
    .in_rs2_data(cur.rs2d), .in_imm(cur.imm), .in_rs1_addr(cur.rs1),
    .in_rs2_addr(cur.rs2), .in_rd_addr(cur.rd), .in_aluop(cur.aluop),
    .in_op1_sel(cur.op1sel), .in_op2_sel(cur.op2sel),
    .in_mem_read(cur.mr), .in_mem_write(cur.mw), .in_reg_write(cur.rw),
    .exmem_rd_addr(ex_rd), .exmem_reg_write(ex_rw), .exmem_result(ex_res),
    .memwb_rd_addr(wb_rd), .memwb_reg_write(wb_rw), .memwb_result(wb_res),
    .flush(flush), .hold(hold),
    .data1(data1), .data2(data2), .select(select),
    .out_valid(out_valid), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_rd_addr(out_rd_addr), .out_pc(out_pc),
    .out_store_data(out_store_data), .stall(stall)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Value a consumer of register 'a' should see after forwarding
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0 && ex_rw && ex_rd == a) return ex_res;
    if (a != 5'd0 && wb_rw && wb_rd == a) return wb_res;
    return d;
  endfunction

  function automatic logic model_hazard();
    return m.valid && m.mr && m.rd != 5'd0 && cur.valid &&
           (cur.rs1 == m.rd || cur.rs2 == m.rd);
  endfunction

  function automatic instr_t kill(input instr_t i);
    instr_t r = i;
    r.valid = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.rw = 1'b0; r.aluop = 5'd0;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid  = ($urandom % 8) != 0;
    r.pc     = $urandom; r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom;
    r.rs1    = 5'($urandom % 4); r.rs2 = 5'($urandom % 4); r.rd = 5'($urandom % 4);
    r.aluop  = 5'($urandom); r.op1sel = 1'($urandom); r.op2sel = 1'($urandom);
    r.mr     = ($urandom % 3) == 0;
    r.mw     = !r.mr && (($urandom % 4) == 0);
    r.rw     = 1'($urandom);
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic hz;
    hz = model_hazard();
    chk({tag, ".stall"}, 32'((hz | hold) & ~flush), 32'(stall));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m.valid));
    chk({tag, ".select"}, 32'(select), m.valid ? 32'(m.aluop) : 32'd0);
    chk({tag, ".ctl"}, 32'({out_mem_read, out_mem_write, out_reg_write}),
        32'({m.valid & m.mr, m.valid & m.mw, m.valid & m.rw}));
    if (m.valid) begin
      chk({tag, ".data1"}, data1, m.op1sel ? m.pc : fwd(m.rs1, m.rs1d));
      chk({tag, ".data2"}, data2, m.op2sel ? m.imm : fwd(m.rs2, m.rs2d));
      chk({tag, ".store"}, out_store_data, fwd(m.rs2, m.rs2d));
      chk({tag, ".pc"}, out_pc, m.pc);
      chk({tag, ".rd"}, 32'(out_rd_addr), 32'(m.rd));
    end
`ifdef ID_EX_STALL_CNT_EN
    chk({tag, ".cnt"}, 32'(stall_count), cnt);
`endif
  endtask

  // Check, then advance one clock with model update; returns at negedge
  task automatic cyc(input string tag);
    #1 check_all(tag);
    if (flush) nm = kill(m);
    else if (hold) nm = m;
    else if (model_hazard()) begin
      nm = kill(m);
      if (cnt != 32'hFFFF) cnt++;
    end else nm = cur.valid ? cur : kill(cur);
    @(posedge clk);
    m = nm;
    @(negedge clk);
  endtask

  task automatic clear_side();
    flush = 0; hold = 0;
    ex_rd = 0; ex_rw = 0; ex_res = 0; wb_rd = 0; wb_rw = 0; wb_res = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; cur = '0; clear_side();
    #1 m = '0; cnt = 0;
    check_all(tag);
    chk({tag, ".d1"}, data1, 32'd0);
    chk({tag, ".d2"}, data2, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk({tag, ".rel.d1"}, data1, 32'd0);
    chk({tag, ".rel.stall"}, 32'(stall), 32'd0);
    @(negedge clk);
  endtask

  function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic [4:0] op);
    instr_t r = '0;
    r.valid = 1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.mr = mr; r.aluop = op;
    r.rw = 1; r.pc = 32'h40; r.rs1d = 32'h1000 + 32'(rs1); r.rs2d = 32'h2000 + 32'(rs2);
    return r;
  endfunction

  initial begin
    cur = '0; clear_side(); m = '0; cnt = 0; reset = 1'b0;
    @(negedge clk);
    do_reset("rst");

    // Load-use: load rd=5 then dependent ADD
    cur = mk(5'd1, 5'd2, 5'd5, 1'b1, 5'd0); cyc("lu.ld");
    cur = mk(5'd5, 5'd6, 5'd7, 1'b0, 5'd1);
    #1 chk("lu.stall1", 32'(stall), 32'd1);
    cyc("lu.haz");
    #1 chk("lu.bub.valid", 32'(out_valid), 32'd0);
    chk("lu.bub.sel", 32'(select), 32'd0);
    chk("lu.bub.stall", 32'(stall), 32'd0);
    cyc("lu.bub");
    #1 chk("lu.add.sel", 32'(select), 32'd1);
    cyc("lu.add");

    // Forwarding priority
    cur = mk(5'd3, 5'd4, 5'd8, 1'b0, 5'd2); cyc("fw.ld");
    cur.valid = 0;
    ex_rd = 3; ex_rw = 1; ex_res = 32'h11; wb_rd = 3; wb_rw = 1; wb_res = 32'h22;
    #1 chk("fw.ex", data1, 32'h11);
    check_all("fw.both");
    ex_rw = 0;
    #1 chk("fw.wb", data1, 32'h22);
    check_all("fw.wbonly");
    clear_side();
    cyc("fw.end");

    // x0 never forwarded
    cur = mk(5'd1, 5'd0, 5'd8, 1'b0, 5'd2); cur.rs2d = 0; cyc("x0.ld");
    cur.valid = 0; ex_rd = 0; ex_rw = 1; ex_res = 32'hFFFF;
    #1 chk("x0.d2", data2, 32'd0);
    chk("x0.st", out_store_data, 32'd0);
    cyc("x0");
    clear_side();

    // PC/IMM operand selects
    cur = mk(5'd1, 5'd2, 5'd3, 1'b0, 5'd0);
    cur.op1sel = 1; cur.pc = 32'h100; cur.op2sel = 1; cur.imm = 32'h8;
    cyc("sel.ld");
    cur.valid = 0;
    #1 chk("sel.d1", data1, 32'h100);
    chk("sel.d2", data2, 32'h8);
    chk("sel.op", 32'(select), 32'd0);
    cyc("sel");

    // Hold for three cycles, then flush overrides hold
    cur = mk(5'd1, 5'd2, 5'd9, 1'b0, 5'd7); cyc("hd.ld");
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      cur = rand_instr();
      #1 chk("hd.sel", 32'(select), 32'd7);
      chk("hd.stall", 32'(stall), 32'd1);
      cyc("hd");
    end
    flush = 1;
    #1 chk("fl.stall", 32'(stall), 32'd0);
    cyc("fl");
    #1 chk("fl.valid", 32'(out_valid), 32'd0);
    clear_side();

    // Reset in the middle of a held load-use hazard
    cur = mk(5'd1, 5'd2, 5'd4, 1'b1, 5'd3); cyc("rh.ld");
    hold = 1; cur = mk(5'd4, 5'd4, 5'd6, 1'b0, 5'd5); cyc("rh.hold");
    reset = 1; #2 m = '0; cnt = 0;
    chk("rh.valid", 32'(out_valid), 32'd0);
    chk("rh.stall", 32'(stall), 32'd1);
    @(negedge clk); reset = 0; hold = 0;
    cyc("rh.rel");
    #1 chk("rh.loaded", 32'(out_valid), 32'd1);

`ifdef ID_EX_STALL_CNT_EN
    // Three bubbles then asynchronous reset of the counter
    do_reset("cnt.rst");
    for (int i = 0; i < 3; i++) begin
      cur = mk(5'd1, 5'd2, 5'd5, 1'b1, 5'd0); cyc("cnt.ld");
      cur = mk(5'd5, 5'd1, 5'd6, 1'b0, 5'd1); cyc("cnt.haz");
      cur.valid = 0; cyc("cnt.bub");
    end
    #1 chk("cnt.three", 32'(stall_count), 32'd3);
    #1 reset = 1;
    #1 chk("cnt.async", 32'(stall_count), 32'd0);
    m = '0; cnt = 0;
    @(negedge clk); reset = 0; @(negedge clk);
`endif

    // Randomized traffic against the model
    do_reset("rnd.rst");
    for (int i = 0; i < 600; i++) begin
      cur    = rand_instr();
      flush  = ($urandom % 10) == 0;
      hold   = ($urandom % 6) == 0;
      ex_rd  = 5'($urandom % 4); ex_rw = 1'($urandom); ex_res = $urandom;
      wb_rd  = 5'($urandom % 4); wb_rw = 1'($urandom); wb_res = $urandom;
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have: CLK  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: IN_VALID in 1; IN_PC, IN_RS1_DATA, IN_RS2_DATA, IN_IMM in 32 each; IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR in 5 each; IN_ALUOP in 5; IN_OP1_SEL in 1 (1=PC, 0=rs1); IN_OP2_SEL in 1 (1=IMM, 0=rs2); IN_MEM_READ, IN_MEM_WRITE, IN_REG_WRITE in 1 each. These are the decoded instruction from ID.
REQ-004 SHALL have forwarding inputs: EXMEM_RD_ADDR in 5, EXMEM_REG_WRITE in 1, EXMEM_RESULT in 32, MEMWB_RD_ADDR in 5, MEMWB_REG_WRITE in 1, MEMWB_RESULT in 32.
REQ-005 SHALL have: FLUSH in 1 (branch taken, kill ID/EX contents); HOLD in 1 (downstream busy, freeze).
REQ-006 SHALL have outputs to ALU: DATA1 out 32, DATA2 out 32, SELECT out 5.
REQ-007 SHALL have: OUT_VALID, OUT_MEM_READ, OUT_MEM_WRITE, OUT_REG_WRITE out 1 each; OUT_RD_ADDR out 5; OUT_PC out 32; OUT_STORE_DATA out 32 (forwarded rs2); STALL out 1 (freeze PC and IF/ID).

Function
REQ-008 Register bank SHALL hold valid, PC, rs1/rs2 data, IMM, rs1/rs2/rd addresses, ALUOP, op selects, mem/regwrite controls.
REQ-009 Update priority each edge SHALL be: FLUSH > HOLD > load-use bubble > normal load.
REQ-010 FLUSH SHALL clear valid, MEM_READ, MEM_WRITE, REG_WRITE, ALUOP=5'b00000; data fields don't-care.
REQ-011 HOLD (no FLUSH) SHALL retain all registered fields unchanged.
REQ-012 Load-use hazard SHALL be: registered valid & registered MEM_READ & registered rd!=0 & IN_VALID & (IN_RS1_ADDR==rd | IN_RS2_ADDR==rd).
REQ-013 On hazard (no FLUSH/HOLD) register SHALL load a bubble (as REQ-010); hazard lasts exactly one cycle per load.
REQ-014 Normal load SHALL capture all IN_* fields; IN_VALID=0 captures a bubble.
REQ-015 STALL SHALL be combinational = (hazard | HOLD) & ~FLUSH.
REQ-016 Forwarded rs1 SHALL be: EXMEM_RESULT if EXMEM_REG_WRITE & EXMEM_RD_ADDR!=0 & ==reg rs1; else MEMWB_RESULT if same conditions on MEMWB; else registered rs1 data. rs2 identical. EX/MEM wins when both match.
REQ-017 Address 0 SHALL never be forwarded; forwarded value of x0 is registered data.
REQ-018 DATA1 SHALL = OP1_SEL ? PC : fwd rs1; DATA2 SHALL = OP2_SEL ? IMM : fwd rs2; OUT_STORE_DATA SHALL = fwd rs2 always.
REQ-019 SELECT SHALL = registered ALUOP when valid, else 5'b00000; OUT_* controls SHALL be gated by valid.
REQ-020 Forwarding and output muxing SHALL be combinational, zero added latency; ID->ALU inputs latency one cycle.

Reset
REQ-021 RESET SHALL asynchronously clear all registers: valid 0, controls 0, ALUOP 0, addresses 0, data 0.
REQ-022 During/after reset DATA1=DATA2=0, SELECT=0, OUT_VALID=0, STALL=0 until a valid instruction loads.
REQ-023 Reset asserted mid-HOLD or mid-hazard SHALL discard the held instruction; no bubble pending after release.

Configuration
REQ-024 With ID_EX_STALL_CNT_EN defined, SHALL add STALL_COUNT out 16: increments each cycle a hazard bubble is inserted (REQ-013), saturates at 16'hFFFF, cleared by RESET, not counted for HOLD or FLUSH.
REQ-025 Without ID_EX_STALL_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 Load rd=5 valid, then ADD rs1=5 rs2=6 presented -> STALL=1 one cycle, next OUT_VALID=0, SELECT=0; following cycle ADD loads, STALL=0.
REQ-027 Registered rs1=3, EXMEM rd=3 RESULT=0x11, MEMWB rd=3 RESULT=0x22, both regwrite -> DATA1=0x11; drop EXMEM_REG_WRITE -> DATA1=0x22.
REQ-028 Registered rs2=0, EXMEM rd=0 regwrite RESULT=0xFFFF, rs2 data 0 -> DATA2=0, OUT_STORE_DATA=0.
REQ-029 OP1_SEL=1 PC=0x100, OP2_SEL=1 IMM=0x8, ALUOP=00000 -> DATA1=0x100, DATA2=0x8, SELECT=0.
REQ-030 HOLD=1 three cycles with new IN_* each -> outputs unchanged, STALL=1; FLUSH with HOLD -> OUT_VALID=0 next edge, STALL=0.
REQ-031 With ID_EX_STALL_CNT_EN: three load-use bubbles then RESET mid-stream -> STALL_COUNT 3 then 0 asynchronously.
